axis_pkt_gen_tx: RTL and testbench

- Transmit-side traffic generator for the 25GE QSFP MAC loopback system. It drives the MAC TX AXI-Stream with numbered Ethernet frames once `mac_ready` is asserted.
- It is the sending end for the existing receive-side pkt_mon checker, so loopback traffic is actually produced instead of the link sitting idle.
- Frame content is deterministic, so pkt_mon can verify every byte.

---
 rtl/axis_pkt_gen_pkg.sv | 35 +++
 rtl/axis_pkt_gen_beat.sv | 57 +++++
 rtl/axis_pkt_gen_tx.sv | 178 +++++++++++++++++
 tb/tb_axis_pkt_gen_tx.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axis_pkt_gen_pkg
// Purpose  : shared types and constants for the AXIS test-frame generator.
// Revision : 1.0
// ============================================================================
package axis_pkt_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SEND     = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [15:0] ETHERTYPE_TEST = 16'h88B5;
  localparam int          HDR_BYTES      = 18;
  localparam int          KEEP_MAX       = 128;

  // Byte-enable mask of the final beat; callers take the low keep_w bits.
  function automatic logic [KEEP_MAX-1:0] last_keep(input int pkt_len, input int keep_w);
    int                  rem;
    logic [KEEP_MAX-1:0] mask;
    rem = pkt_len % keep_w;
    if (rem == 0) rem = keep_w;
    mask = '0;
    for (int b = 0; b < KEEP_MAX; b++) begin
      if (b < rem) mask[b] = 1'b1;
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pkt_gen_beat.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen_beat
// Purpose  : combinational builder of one frame beat (tdata/tkeep/last flag).
// Revision : 1.0
// ============================================================================
module axis_pkt_gen_beat
  import axis_pkt_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          PKT_LEN    = 64,
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h000A_3501_0203
) (
  input  logic [15:0]             beat_idx,
  input  logic [31:0]             seq,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic [DATA_WIDTH/8-1:0] tkeep,
  output logic                    tlast
);

  localparam int                  KEEP_W        = DATA_WIDTH / 8;
  localparam int                  BEATS         = (PKT_LEN + KEEP_W - 1) / KEEP_W;
  localparam logic [KEEP_MAX-1:0] LAST_KEEP_ALL = last_keep(PKT_LEN, KEEP_W);
  localparam logic [KEEP_W-1:0]   LAST_KEEP     = LAST_KEEP_ALL[KEEP_W-1:0];
  // Wire bytes 0..13, byte 0 in the top octet.
  localparam logic [111:0]        HDR           = {DST_MAC, SRC_MAC, ETHERTYPE_TEST};

  assign tlast = (beat_idx == 16'(BEATS - 1));
  assign tkeep = tlast ? LAST_KEEP : '1;

  for (genvar b = 0; b < KEEP_W; b++) begin : g_lane
    logic [31:0] byte_idx;
    logic [7:0]  byte_val;

    assign byte_idx = 32'(beat_idx) * 32'(KEEP_W) + 32'(b);

    always_comb begin
      byte_val = seq[7:0] + byte_idx[7:0];
      if (byte_idx < 32'd14) begin
        byte_val = 8'(HDR >> {4'd13 - byte_idx[3:0], 3'b000});
      end else if (byte_idx < 32'(HDR_BYTES)) begin
        case (byte_idx[4:0])
          5'd14:   byte_val = seq[31:24];
          5'd15:   byte_val = seq[23:16];
          5'd16:   byte_val = seq[15:8];
          default: byte_val = seq[7:0];
        endcase
      end
      if (byte_idx >= 32'(PKT_LEN)) byte_val = 8'h00;
    end

    assign tdata[8*b +: 8] = byte_val;
  end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_gen_tx.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen_tx
// Purpose  : numbered test-frame generator driving the MAC TX AXI-Stream.
//            Error injection (err_every / tx_err_cnt): AXIS_PKT_GEN_ERR_INJECT_EN.
// Revision : 1.0
// ============================================================================
module axis_pkt_gen_tx
  import axis_pkt_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          PKT_LEN    = 64,
  parameter int          NUM_PKTS   = 16,
  parameter int          IPG_CYCLES = 4,
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h000A_3501_0203
) (
  input  logic                    clk,
  input  logic                    sys_reset,
  input  logic                    mac_ready,
  input  logic                    start,
  input  logic                    stop,
  output logic [DATA_WIDTH-1:0]   tx_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] tx_axis_tkeep,
  output logic                    tx_axis_tvalid,
  output logic                    tx_axis_tlast,
  output logic                    tx_axis_tuser,
  input  logic                    tx_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             tx_pkt_cnt,
  output logic [47:0]             tx_byte_cnt
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
  ,
  input  logic [7:0]              err_every,
  output logic [31:0]             tx_err_cnt
`endif
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  state_e              state_q, state_d;
  logic [15:0]         beat_q, beat_d;
  logic [15:0]         gap_q, gap_d;
  logic                stop_pend_q, stop_pend_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic [47:0]         byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [KEEP_W-1:0]   beat_keep;
  logic                beat_last;
  logic                xfer, last_xfer, stop_any, err_frame, run_end;

  // The sequence number is the completed-frame count, which only moves after tlast.
  axis_pkt_gen_beat #(
    .DATA_WIDTH (DATA_WIDTH),
    .PKT_LEN    (PKT_LEN),
    .DST_MAC    (DST_MAC),
    .SRC_MAC    (SRC_MAC)
  ) u_beat (
    .beat_idx (beat_q),
    .seq      (pkt_cnt_q),
    .tdata    (beat_data),
    .tkeep    (beat_keep),
    .tlast    (beat_last)
  );

  assign tx_axis_tvalid = (state_q == ST_SEND);
  assign tx_axis_tdata  = tx_axis_tvalid ? beat_data : '0;
  assign tx_axis_tkeep  = tx_axis_tvalid ? beat_keep : '0;
  assign tx_axis_tlast  = tx_axis_tvalid & beat_last;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign tx_pkt_cnt     = pkt_cnt_q;
  assign tx_byte_cnt    = byte_cnt_q;
  assign xfer           = tx_axis_tvalid & tx_axis_tready;
  assign last_xfer      = xfer & beat_last;
  assign stop_any       = stop_pend_q | stop;

`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
  logic [31:0] err_cnt_q, err_cnt_d;
  assign err_frame     = (err_every != 8'd0) &&
                         ((pkt_cnt_q % {24'd0, err_every}) == ({24'd0, err_every} - 32'd1));
  assign tx_axis_tuser = tx_axis_tlast & err_frame;
  assign tx_err_cnt    = err_cnt_q;
`else
  assign err_frame     = 1'b0;
  assign tx_axis_tuser = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    stop_pend_d = stop_pend_q;
    pkt_cnt_d   = pkt_cnt_q;
    byte_cnt_d  = byte_cnt_q;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
    err_cnt_d   = err_cnt_q;
    if (last_xfer && err_frame) err_cnt_d = err_cnt_q + 32'd1;
`endif
    if (busy && stop) stop_pend_d = 1'b1;
    if (last_xfer) begin
      pkt_cnt_d  = pkt_cnt_q + 32'd1;
      byte_cnt_d = byte_cnt_q + 48'(PKT_LEN);
    end
    run_end = stop_any || ((NUM_PKTS != 0) && (pkt_cnt_d == 32'(NUM_PKTS)));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WAIT_RDY;
          beat_d      = '0;
          gap_d       = '0;
          stop_pend_d = 1'b0;
          pkt_cnt_d   = '0;
          byte_cnt_d  = '0;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
          err_cnt_d   = '0;
`endif
        end
      end
      ST_WAIT_RDY: begin
        if (stop_any)       state_d = ST_DONE;
        else if (mac_ready) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          if (beat_last) begin
            beat_d = '0;
            gap_d  = '0;
            if (IPG_CYCLES != 0) state_d = ST_GAP;
            else if (run_end)    state_d = ST_DONE;
            else if (!mac_ready) state_d = ST_WAIT_RDY;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        // Skipping WAIT_RDY when the MAC is ready keeps the gap at exactly IPG_CYCLES.
        if (gap_q == 16'(IPG_CYCLES - 1)) begin
          if (run_end)        state_d = ST_DONE;
          else if (mac_ready) state_d = ST_SEND;
          else                state_d = ST_WAIT_RDY;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      pkt_cnt_q   <= pkt_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_gen_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_gen_tx
// Purpose  : directed bench: default instance plus a PKT_LEN=61, continuous,
//            zero-gap instance.
// Revision : 1.0
// ============================================================================
module tb_axis_pkt_gen_tx;

  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h000A_3501_0203;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_reset, mac_ready, start, stop, tready, start2, stop2, tready2;
  logic [63:0] tdata, tdata2;
  logic [7:0]  tkeep, tkeep2;
  logic        tvalid, tlast, tuser, busy, done;
  logic        tvalid2, tlast2, tuser2, busy2, done2;
  logic [31:0] pkt_cnt, pkt_cnt2;
  logic [47:0] byte_cnt, byte_cnt2;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
  logic [31:0] err_cnt, err_cnt2;
`endif

  int checks   = 0;
  int failures = 0;

  axis_pkt_gen_tx u_dut (
    .clk(clk), .sys_reset(sys_reset), .mac_ready(mac_ready), .start(start), .stop(stop),
    .tx_axis_tdata(tdata), .tx_axis_tkeep(tkeep), .tx_axis_tvalid(tvalid),
    .tx_axis_tlast(tlast), .tx_axis_tuser(tuser), .tx_axis_tready(tready),
    .busy(busy), .done(done), .tx_pkt_cnt(pkt_cnt), .tx_byte_cnt(byte_cnt)
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
    , .err_every(8'd0), .tx_err_cnt(err_cnt)
`endif
  );

  axis_pkt_gen_tx #(.PKT_LEN(61), .NUM_PKTS(0), .IPG_CYCLES(0)) u_dut2 (
    .clk(clk), .sys_reset(sys_reset), .mac_ready(mac_ready), .start(start2), .stop(stop2),
    .tx_axis_tdata(tdata2), .tx_axis_tkeep(tkeep2), .tx_axis_tvalid(tvalid2),
    .tx_axis_tlast(tlast2), .tx_axis_tuser(tuser2), .tx_axis_tready(tready2),
    .busy(busy2), .done(done2), .tx_pkt_cnt(pkt_cnt2), .tx_byte_cnt(byte_cnt2)
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
    , .err_every(8'd0), .tx_err_cnt(err_cnt2)
`endif
  );

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] seq);
    logic [47:0] d;
    logic [47:0] s;
    d = DST;
    s = SRC;
    if (i < 6)   return d[8*(5-i) +: 8];
    if (i < 12)  return s[8*(11-i) +: 8];
    if (i == 12) return 8'h88;
    if (i == 13) return 8'hB5;
    if (i < 18)  return seq[8*(17-i) +: 8];
    return 8'(seq[7:0] + 8'(i));
  endfunction

  function automatic logic [63:0] exp_beat(input int frame, input int beat, input int len);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < 8; l++) begin
      if (beat*8 + l < len) v[8*l +: 8] = exp_byte(beat*8 + l, 32'(frame));
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_keep(input int beat, input int len);
    int nb;
    int rem;
    nb  = (len + 7) / 8;
    rem = len % 8;
    if (beat != nb - 1 || rem == 0) return 8'hFF;
    return 8'((1 << rem) - 1);
  endfunction

  function automatic logic [63:0] keep_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int l = 0; l < 8; l++) m[8*l +: 8] = {8{k[l]}};
    return m;
  endfunction

  task automatic test_reset();
    sys_reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tvalid, tlast, tuser, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=00000", {tvalid, tlast, tuser, busy, done});
    end
    checks++;
    if (pkt_cnt !== 32'd0 || byte_cnt !== 48'd0) begin
      failures++;
      $display("FAIL reset_cnt actual pkt=%0d bytes=%0d required 0/0", pkt_cnt, byte_cnt);
    end
    checks++;
    if (tdata !== 64'd0 || tkeep !== 8'd0) begin
      failures++;
      $display("FAIL reset_data actual tdata=%h tkeep=%h required 0/0", tdata, tkeep);
    end
    checks++;
    if ({tvalid2, busy2, done2} !== 3'b0 || pkt_cnt2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_dut2 actual=%b pkt=%0d required 000/0", {tvalid2, busy2, done2}, pkt_cnt2);
    end
    sys_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_defaults();
    int frame = 0;
    int beat = 0;
    int idle = 0;
    int gap_bad = 0;
    int data_bad = 0;
    int keep_bad = 0;
    int last_bad = 0;
    logic [31:0] seq5 = 32'hFFFF_FFFF;
    mac_ready = 1'b1;
    tready    = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_rdy_cycle actual tvalid=%b busy=%b required 0/1", tvalid, busy);
    end
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b1) begin
      failures++;
      $display("FAIL start_latency actual tvalid=%b required 1 two cycles after start", tvalid);
    end
    for (int cyc = 0; cyc < 400 && done !== 1'b1; cyc++) begin
      if (tvalid) begin
        if (frame > 0 && beat == 0 && idle != 4) gap_bad++;
        idle = 0;
        if ((tdata & keep_mask(exp_keep(beat, 64))) !== exp_beat(frame, beat, 64)) data_bad++;
        if (tkeep !== exp_keep(beat, 64)) keep_bad++;
        if (tlast !== (beat == 7)) last_bad++;
        if (frame == 5 && beat == 1) seq5[31:16] = {tdata[55:48], tdata[63:56]};
        if (frame == 5 && beat == 2) seq5[15:0]  = {tdata[7:0], tdata[15:8]};
        if (beat == 7) begin frame++; beat = 0; end else beat++;
      end else begin
        idle++;
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_done actual done=%b busy=%b required 1/0", done, busy);
    end
    checks++;
    if (frame != 16 || pkt_cnt !== 32'd16) begin
      failures++;
      $display("FAIL frame_count actual seen=%0d cnt=%0d required 16", frame, pkt_cnt);
    end
    checks++;
    if (byte_cnt !== 48'd1024) begin
      failures++;
      $display("FAIL byte_count actual=%0d required 1024", byte_cnt);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL ipg actual bad_gaps=%0d required 0 (4 idle cycles each)", gap_bad);
    end
    checks++;
    if (data_bad != 0 || keep_bad != 0 || last_bad != 0) begin
      failures++;
      $display("FAIL frame_content actual data=%0d keep=%0d last=%0d bad beats required 0",
               data_bad, keep_bad, last_bad);
    end
    checks++;
    if (seq5 !== 32'd5) begin
      failures++;
      $display("FAIL seq_frame5 actual=%h required 00000005", seq5);
    end
  endtask

  task automatic test_backpressure();
    int frame = 0;
    int beat = 0;
    int hold_bad = 0;
    int data_bad = 0;
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic [7:0] prev_keep = '0;
    logic prev_last = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (pkt_cnt !== 32'd0 || byte_cnt !== 48'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear actual pkt=%0d bytes=%0d done=%b required 0/0/0",
               pkt_cnt, byte_cnt, done);
    end
    for (int cyc = 0; cyc < 2000 && done !== 1'b1; cyc++) begin
      if (tvalid) begin
        if (prev_stall && (tdata !== prev_data || tkeep !== prev_keep || tlast !== prev_last))
          hold_bad++;
        if ((tdata & keep_mask(exp_keep(beat, 64))) !== exp_beat(frame, beat, 64)) data_bad++;
      end else if (prev_stall) begin
        hold_bad++;
      end
      start      = (cyc == 30);
      tready     = 1'($urandom_range(0, 1));
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_keep  = tkeep;
      prev_last  = tlast;
      if (tvalid && tready) begin
        if (beat == 7) begin frame++; beat = 0; end else beat++;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    tready = 1'b1;
    checks++;
    if (hold_bad != 0) begin
      failures++;
      $display("FAIL stall_hold actual unstable_beats=%0d required 0", hold_bad);
    end
    checks++;
    if (data_bad != 0) begin
      failures++;
      $display("FAIL bp_content actual bad_beats=%0d required 0", data_bad);
    end
    checks++;
    if (done !== 1'b1 || frame != 16 || pkt_cnt !== 32'd16 || byte_cnt !== 48'd1024) begin
      failures++;
      $display("FAIL bp_totals actual done=%b seen=%0d pkt=%0d bytes=%0d required 1/16/16/1024",
               done, frame, pkt_cnt, byte_cnt);
    end
  endtask

  task automatic test_mac_ready();
    int frame = 0;
    int beat = 0;
    int found = 0;
    int tail = 0;
    int ended = 0;
    int valid_after = 0;
    int lat = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (tvalid && frame == 1 && beat == 3) begin found = 1; break; end
      if (tvalid) begin
        if (beat == 7) begin frame++; beat = 0; end else beat++;
      end
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL reach_frame1 actual not reached required frame 1 beat 3");
    end
    mac_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tvalid) begin
        if (ended != 0) valid_after++;
        else begin
          tail++;
          if (tlast) ended = 1;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ended != 1 || tail != 5) begin
      failures++;
      $display("FAIL frame_finish actual ended=%0d beats=%0d required 1/5", ended, tail);
    end
    checks++;
    if (valid_after != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_while_down actual valid=%0d busy=%b required 0/1", valid_after, busy);
    end
    mac_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (tvalid) begin lat = i; break; end
    end
    checks++;
    if (lat < 1 || lat > 2) begin
      failures++;
      $display("FAIL resume_latency actual=%0d required 1..2 cycles", lat);
    end
    checks++;
    if (pkt_cnt !== 32'd2 || tdata !== exp_beat(2, 0, 64)) begin
      failures++;
      $display("FAIL resume_frame actual pkt=%0d tdata=%h required 2/%h",
               pkt_cnt, tdata, exp_beat(2, 0, 64));
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pkt_cnt !== 32'd3) begin
      failures++;
      $display("FAIL stop_after_resume actual done=%b pkt=%0d required 1/3", done, pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int frame = 0;
    int beat = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (tvalid && frame == 2 && beat == 4) break;
      if (tvalid) begin
        if (beat == 7) begin frame++; beat = 0; end else beat++;
      end
      @(negedge clk);
    end
    checks++;
    if (tvalid !== 1'b1 || pkt_cnt !== 32'd2) begin
      failures++;
      $display("FAIL pre_reset actual tvalid=%b pkt=%0d required 1/2", tvalid, pkt_cnt);
    end
    sys_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tvalid, busy, done} !== 3'b0 || pkt_cnt !== 32'd0 || byte_cnt !== 48'd0) begin
      failures++;
      $display("FAIL mid_reset actual v/b/d=%b pkt=%0d bytes=%0d required 000/0/0",
               {tvalid, busy, done}, pkt_cnt, byte_cnt);
    end
    sys_reset = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b1) begin
      failures++;
      $display("FAIL restart_valid actual=%b required 1", tvalid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (tdata[23:0] !== 24'h120000) begin
      failures++;
      $display("FAIL restart_seq actual bytes16-18=%h required 120000", tdata[23:0]);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic test_stop_cont();
    int frame = 0;
    int beat = 0;
    int idle = 0;
    int started = 0;
    int data_bad = 0;
    int keep_bad = 0;
    int last_bad = 0;
    logic [7:0] first_last_keep = 8'h00;
    tready2 = 1'b1;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int cyc = 0; cyc < 300 && done2 !== 1'b1; cyc++) begin
      stop2 = 1'b0;
      if (tvalid2) begin
        started = 1;
        if ((tdata2 & keep_mask(exp_keep(beat, 61))) !== exp_beat(frame, beat, 61)) data_bad++;
        if (tkeep2 !== exp_keep(beat, 61)) keep_bad++;
        if (tlast2 !== (beat == 7)) last_bad++;
        if (frame == 0 && beat == 7) first_last_keep = tkeep2;
        if (frame == 7 && beat == 3) stop2 = 1'b1;
        if (beat == 7) begin frame++; beat = 0; end else beat++;
      end else if (started != 0) begin
        idle++;
      end
      @(negedge clk);
    end
    stop2 = 1'b0;
    checks++;
    if (first_last_keep !== 8'h1F) begin
      failures++;
      $display("FAIL len61_last_keep actual=%h required 1f", first_last_keep);
    end
    checks++;
    if (data_bad != 0 || keep_bad != 0 || last_bad != 0) begin
      failures++;
      $display("FAIL len61_content actual data=%0d keep=%0d last=%0d bad beats required 0",
               data_bad, keep_bad, last_bad);
    end
    checks++;
    if (idle != 0) begin
      failures++;
      $display("FAIL zero_ipg actual idle_cycles=%0d required 0", idle);
    end
    checks++;
    if (done2 !== 1'b1 || frame != 8 || pkt_cnt2 !== 32'd8) begin
      failures++;
      $display("FAIL stop_cont actual done=%b seen=%0d pkt=%0d required 1/8/8", done2, frame, pkt_cnt2);
    end
    checks++;
    if (byte_cnt2 !== 48'd488) begin
      failures++;
      $display("FAIL len61_bytes actual=%0d required 488", byte_cnt2);
    end
  endtask

  initial begin
    sys_reset = 1'b1;
    mac_ready = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    tready    = 1'b1;
    start2    = 1'b0;
    stop2     = 1'b0;
    tready2   = 1'b1;
    test_reset();
    test_defaults();
    test_backpressure();
    test_mac_ready();
    test_reset_mid();
    test_stop_cont();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
